// File: rtl/async_fifo.sv
// Single-clock FIFO buffer (name kept for compatibility) with asynchronous active-low reset.
// Wrap-bit pointers give full/empty without an occupancy counter; storage has no reset so it maps to block RAM.
module async_fifo #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [FIFO_WIDTH-1:0] r_dout;

    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
    assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

    // Flags come straight from the registered pointers, so they are valid for the whole cycle.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) && (w_wr_addr == w_rd_addr);

    assign w_wr_accept = wr_en && !full;
    assign w_rd_accept = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[w_wr_addr] <= din;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_dout   <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            // Read is taken from the pre-edge contents: no write-through when empty.
            if (w_rd_accept) begin
                r_dout   <= r_mem[w_rd_addr];
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: randomized traffic against a queue-based model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_async_fifo;

    localparam int W = 8;
    localparam int D = 16;
    localparam int A = 4;

    logic         clk;
    logic         n_rst;
    logic         wr_en;
    logic [W-1:0] din;
    logic         rd_en;
    logic [W-1:0] dout;
    logic         full;
    logic         empty;

    int n_checks;
    int n_fail;

    logic [W-1:0] model_q[$];
    logic [W-1:0] exp_dout;

    async_fifo #(
        .FIFO_WIDTH(W),
        .FIFO_DEPTH(D),
        .ADDR_WIDTH(A)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .wr_en(wr_en),
        .din  (din),
        .rd_en(rd_en),
        .dout (dout),
        .full (full),
        .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of requests (called just after a falling edge), update the model,
    // and return at the next falling edge ready for sampling.
    task automatic step(input logic w, input logic [W-1:0] d, input logic r);
        bit w_ok;
        bit r_ok;
        wr_en = w;
        din   = d;
        rd_en = r;
        w_ok  = w && (model_q.size() < D);
        r_ok  = r && (model_q.size() > 0);
        if (r_ok) exp_dout = model_q.pop_front();
        if (w_ok) model_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        wr_en = 1'b1;
        rd_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            din = W'($urandom);
            @(negedge clk);
            if (empty !== 1'b1 || full !== 1'b0 || dout !== '0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: empty=%b full=%b dout=%h expected empty=1 full=0 dout=00",
                         i, empty, full, dout);
            end
            n_checks++;
        end
        wr_en = 1'b0;
        n_rst = 1'b1;
        model_q.delete();
        exp_dout = '0;
        @(negedge clk);
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: empty=%b full=%b expected empty=1 full=0", empty, full);
        end
        n_checks++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < D + 2; i++) begin
            step(1'b1, (i < D) ? W'(i) : W'(15), 1'b0);
            if (full !== (model_q.size() == D) || empty !== 1'b0 || dout !== exp_dout) begin
                n_fail++;
                $display("FAIL fill write %0d: full=%b empty=%b dout=%h expected full=%b empty=0 dout=%h",
                         i, full, empty, dout, (model_q.size() == D), exp_dout);
            end
            n_checks++;
        end
        if (model_q.size() != D || full !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: full=%b expected 1 (model size %0d)", full, model_q.size());
        end
        n_checks++;
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, '0, 1'b1);
            if (dout !== exp_dout || dout !== W'((i < D) ? i : 15)) begin
                n_fail++;
                $display("FAIL drain read %0d: dout=%h expected %h", i, dout, W'((i < D) ? i : 15));
            end
            n_checks++;
            if (empty !== (model_q.size() == 0) || full !== 1'b0) begin
                n_fail++;
                $display("FAIL drain flags %0d: empty=%b full=%b expected empty=%b full=0",
                         i, empty, full, (model_q.size() == 0));
            end
            n_checks++;
        end
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, W'(8'h20 + i), 1'b1);
            if (dout !== exp_dout || full !== 1'b0 || empty !== 1'b0 || model_q.size() != 4) begin
                n_fail++;
                $display("FAIL concurrent %0d: dout=%h full=%b empty=%b expected dout=%h full=0 empty=0",
                         i, dout, full, empty, exp_dout);
            end
            n_checks++;
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b1);
            if (dout !== exp_dout || empty !== (model_q.size() == 0)) begin
                n_fail++;
                $display("FAIL concurrent_drain %0d: dout=%h empty=%b expected dout=%h empty=%b",
                         i, dout, empty, exp_dout, (model_q.size() == 0));
            end
            n_checks++;
        end
    endtask

    task automatic test_wrap();
        int writes;
        int steps;
        int wp;
        int rp;
        bit w;
        bit r;
        writes = 0;
        steps  = 0;
        while (writes < 40 && steps < 400) begin
            // Alternate write-heavy and read-heavy bursts so both flags get exercised.
            case ((steps / 12) % 3)
                0:       begin wp = 95; rp = 5;  end
                1:       begin wp = 15; rp = 90; end
                default: begin wp = 60; rp = 60; end
            endcase
            w = ($urandom_range(99) < wp);
            r = ($urandom_range(99) < rp);
            if (w && model_q.size() < D) writes++;
            step(w, W'($urandom), r);
            if (dout !== exp_dout || full !== (model_q.size() == D) || empty !== (model_q.size() == 0)) begin
                n_fail++;
                $display("FAIL wrap step %0d: dout=%h full=%b empty=%b expected dout=%h full=%b empty=%b",
                         steps, dout, full, empty, exp_dout, (model_q.size() == D), (model_q.size() == 0));
            end
            n_checks++;
            steps++;
        end
        if (writes < 40) begin
            n_fail++;
            $display("FAIL wrap_budget: only %0d of 40 writes accepted", writes);
        end
        n_checks++;
        while (model_q.size() > 0) begin
            step(1'b0, '0, 1'b1);
            if (dout !== exp_dout) begin
                n_fail++;
                $display("FAIL wrap_drain: dout=%h expected %h", dout, exp_dout);
            end
            n_checks++;
        end
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_empty: empty=%b expected 1", empty);
        end
        n_checks++;
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] fresh;
        for (int i = 0; i < 8; i++) step(1'b1, W'($urandom) | W'(1), 1'b0);
        step(1'b0, '0, 1'b1);
        if (model_q.size() != 7 || dout !== exp_dout || dout === '0) begin
            n_fail++;
            $display("FAIL midrst_setup: dout=%h expected %h (stored %0d)", dout, exp_dout, model_q.size());
        end
        n_checks++;
        #2 n_rst = 1'b0;
        #1;
        if (empty !== 1'b1 || full !== 1'b0 || dout !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: empty=%b full=%b dout=%h expected empty=1 full=0 dout=00",
                     empty, full, dout);
        end
        n_checks++;
        #1 n_rst = 1'b1;
        model_q.delete();
        exp_dout = '0;
        @(negedge clk);
        fresh = W'($urandom);
        step(1'b1, fresh, 1'b0);
        step(1'b0, '0, 1'b1);
        if (dout !== fresh || exp_dout !== fresh || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_new_data: dout=%h empty=%b expected dout=%h empty=1", dout, empty, fresh);
        end
        n_checks++;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_rst    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        exp_dout = '0;
        @(negedge clk);
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_concurrent();
        test_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
